// File: rtl/pipe_ctrl.sv
// Pipeline control unit: stall/flush generation, exception and interrupt entry, ERET return.
// Exceptions redirect through a two-cycle FLUSH -> REDIRECT sequence; ERET redirects in place.
module pipe_ctrl #(
  parameter int unsigned WORD_ADDR_WIDTH = 30,
  parameter int unsigned ISA_EXP_BUS     = 3,
  parameter int unsigned CTRL_OP_BUS     = 2,
  parameter logic [WORD_ADDR_WIDTH-1:0] EXC_VECTOR = 30'h40
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       if_busy_i,
  input  logic                       mem_busy_i,
  input  logic                       ld_hazard_i,
  input  logic                       irq_i,
  input  logic                       mem_en_i,
  input  logic [WORD_ADDR_WIDTH-1:0] mem_pc_i,
  input  logic [ISA_EXP_BUS-1:0]     mem_exp_code_i,
  input  logic [CTRL_OP_BUS-1:0]     mem_ctrl_op_i,
  output logic                       if_stall_o,
  output logic                       id_stall_o,
  output logic                       ex_stall_o,
  output logic                       mem_stall_o,
  output logic                       if_flush_o,
  output logic                       id_flush_o,
  output logic                       ex_flush_o,
  output logic                       mem_flush_o,
  output logic [WORD_ADDR_WIDTH-1:0] new_pc_o,
  output logic                       new_pc_vld_o,
  output logic                       int_detect_o,
  output logic [WORD_ADDR_WIDTH-1:0] epc_o,
  output logic [ISA_EXP_BUS-1:0]     exp_code_o,
  output logic                       ie_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  localparam logic [CTRL_OP_BUS-1:0] OP_ERET  = CTRL_OP_BUS'(2);
  localparam logic [ISA_EXP_BUS-1:0] CODE_IRQ = ISA_EXP_BUS'(1);

  state_e                     state_q, state_d;
  logic [WORD_ADDR_WIDTH-1:0] new_pc_q, new_pc_d;
  logic [WORD_ADDR_WIDTH-1:0] epc_q, epc_d;
  logic [ISA_EXP_BUS-1:0]     exp_code_q, exp_code_d;
  logic                       ie_q, ie_d;

  // Stage vectors are ordered {IF, ID, EX, MEM}.
  logic [3:0] stall, flush;
  logic       int_detect, new_pc_vld;
  logic       exc_evt, irq_evt, eret_evt;

  assign exc_evt  = mem_en_i && (mem_exp_code_i != '0);
  assign irq_evt  = irq_i && ie_q && mem_en_i;
  assign eret_evt = mem_en_i && (mem_ctrl_op_i == OP_ERET) && !exc_evt && !irq_evt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      new_pc_q   <= '0;
      epc_q      <= '0;
      exp_code_q <= '0;
      ie_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      new_pc_q   <= new_pc_d;
      epc_q      <= epc_d;
      exp_code_q <= exp_code_d;
      ie_q       <= ie_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    new_pc_d   = new_pc_q;
    epc_d      = epc_q;
    exp_code_d = exp_code_q;
    ie_d       = ie_q;
    stall      = '0;
    flush      = '0;
    int_detect = 1'b0;
    new_pc_vld = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_busy_i) begin
          stall = 4'b1111;
        end else if (exc_evt || irq_evt) begin
          int_detect = 1'b1;
          flush      = 4'b1111;
          epc_d      = mem_pc_i;
          exp_code_d = exc_evt ? mem_exp_code_i : CODE_IRQ;
          ie_d       = 1'b0;
          state_d    = FLUSH;
        end else begin
          if (ld_hazard_i) begin
            stall[3] = 1'b1;
            stall[2] = 1'b1;
            flush[1] = 1'b1;
          end else if (if_busy_i) begin
            stall[3] = 1'b1;
            flush[2] = 1'b1;
          end
          if (eret_evt) begin
            flush      = flush | 4'b1110;
            new_pc_vld = 1'b1;
            new_pc_d   = epc_q;
            ie_d       = 1'b1;
          end
        end
      end
      FLUSH: begin
        flush   = 4'b1111;
        state_d = REDIRECT;
      end
      REDIRECT: begin
        new_pc_vld = 1'b1;
        new_pc_d   = EXC_VECTOR;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase

    // A flush always overrides a stall on the same stage.
    stall = stall & ~flush;

    // Keep controls quiet while reset is asserted so an aborted sequence never strobes.
    if (rst_i) begin
      stall      = '0;
      flush      = '0;
      int_detect = 1'b0;
      new_pc_vld = 1'b0;
      new_pc_d   = new_pc_q;
    end
  end

  assign {if_stall_o, id_stall_o, ex_stall_o, mem_stall_o} = stall;
  assign {if_flush_o, id_flush_o, ex_flush_o, mem_flush_o} = flush;
  assign int_detect_o = int_detect;
  assign new_pc_vld_o = new_pc_vld;
  assign new_pc_o     = new_pc_d;
  assign epc_o        = epc_q;
  assign exp_code_o   = exp_code_q;
  assign ie_o         = ie_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a table of single-cycle RUN vectors followed by
// hand-written exception, interrupt, ERET and reset-abort sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifBusy, memBusy, ldHazard, irq, memEn;
  logic [29:0] memPc;
  logic [2:0]  memCode;
  logic [1:0]  memOp;
  logic        ifStall, idStall, exStall, memStall;
  logic        ifFlush, idFlush, exFlush, memFlush;
  logic [29:0] newPc;
  logic        newPcVld, intDetect;
  logic [29:0] epc;
  logic [2:0]  expCode;
  logic        ie;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        ifb, memb, ldh, irq, men;
    logic [2:0]  code;
    logic [1:0]  op;
    logic [3:0]  stall, flush;
    logic        intd, vld;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .if_busy_i(ifBusy), .mem_busy_i(memBusy), .ld_hazard_i(ldHazard),
    .irq_i(irq), .mem_en_i(memEn), .mem_pc_i(memPc),
    .mem_exp_code_i(memCode), .mem_ctrl_op_i(memOp),
    .if_stall_o(ifStall), .id_stall_o(idStall), .ex_stall_o(exStall), .mem_stall_o(memStall),
    .if_flush_o(ifFlush), .id_flush_o(idFlush), .ex_flush_o(exFlush), .mem_flush_o(memFlush),
    .new_pc_o(newPc), .new_pc_vld_o(newPcVld), .int_detect_o(intDetect),
    .epc_o(epc), .exp_code_o(expCode), .ie_o(ie)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkCtl(input string name, input logic [3:0] st, input logic [3:0] fl,
                          input logic intd, input logic vld);
    checkOutput({name, ".stall"}, {28'd0, ifStall, idStall, exStall, memStall}, {28'd0, st});
    checkOutput({name, ".flush"}, {28'd0, ifFlush, idFlush, exFlush, memFlush}, {28'd0, fl});
    checkOutput({name, ".int_detect"}, {31'd0, intDetect}, {31'd0, intd});
    checkOutput({name, ".new_pc_vld"}, {31'd0, newPcVld}, {31'd0, vld});
  endtask

  task automatic setIdle;
    ifBusy = 0; memBusy = 0; ldHazard = 0; irq = 0; memEn = 0;
    memPc = '0; memCode = '0; memOp = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    ifBusy = v.ifb; memBusy = v.memb; ldHazard = v.ldh; irq = v.irq; memEn = v.men;
    memCode = v.code; memOp = v.op; memPc = 30'h3c;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // Fires an exception in RUN and walks it through FLUSH and REDIRECT.
  task automatic runException(input string name, input logic [29:0] pc, input logic [2:0] code);
    setIdle(); memEn = 1; memPc = pc; memCode = code;
    @(negedge clk); checkCtl({name, ".accept"}, 4'b0000, 4'b1111, 1, 0);
    nextCycle(); setIdle();
    @(negedge clk); checkOutput({name, ".epc"}, {2'd0, epc}, {2'd0, pc});
    nextCycle();
    @(negedge clk); checkOutput({name, ".vec"}, {2'd0, newPc}, 32'h40);
    nextCycle();
  endtask

  initial begin
    vecs[0]  = '{"idle",        0,0,0,0,0, 3'd0, 2'd0, 4'b0000, 4'b0000, 0, 0};
    vecs[1]  = '{"ldhaz",       0,0,1,0,0, 3'd0, 2'd0, 4'b1100, 4'b0010, 0, 0};
    vecs[2]  = '{"ldhaz_gone",  0,0,0,0,0, 3'd0, 2'd0, 4'b0000, 4'b0000, 0, 0};
    vecs[3]  = '{"ifbusy",      1,0,0,0,0, 3'd0, 2'd0, 4'b1000, 4'b0100, 0, 0};
    vecs[4]  = '{"ldhaz_ifbusy",1,0,1,0,0, 3'd0, 2'd0, 4'b1100, 4'b0010, 0, 0};
    vecs[5]  = '{"membusy",     0,1,0,0,0, 3'd0, 2'd0, 4'b1111, 4'b0000, 0, 0};
    vecs[6]  = '{"membusy_all", 1,1,1,0,0, 3'd0, 2'd0, 4'b1111, 4'b0000, 0, 0};
    vecs[7]  = '{"membusy_exc", 0,1,0,0,1, 3'd3, 2'd0, 4'b1111, 4'b0000, 0, 0};
    vecs[8]  = '{"membusy_eret",0,1,0,0,1, 3'd0, 2'd2, 4'b1111, 4'b0000, 0, 0};
    vecs[9]  = '{"irq_ie_off",  0,0,0,1,1, 3'd0, 2'd0, 4'b0000, 4'b0000, 0, 0};
    vecs[10] = '{"code_no_en",  0,0,1,1,0, 3'd3, 2'd0, 4'b1100, 4'b0010, 0, 0};

    setIdle();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checkCtl("reset", 4'b0000, 4'b0000, 0, 0);
    checkOutput("reset.new_pc", {2'd0, newPc}, 32'd0);
    checkOutput("reset.epc", {2'd0, epc}, 32'd0);
    checkOutput("reset.exp_code", {29'd0, expCode}, 32'd0);
    checkOutput("reset.ie", {31'd0, ie}, 32'd0);
    nextCycle();

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkCtl(vecs[i].name, vecs[i].stall, vecs[i].flush, vecs[i].intd, vecs[i].vld);
      nextCycle();
    end

    // Exception with busy/hazard inputs asserted during FLUSH and REDIRECT.
    setIdle(); memEn = 1; memCode = 3'd3; memPc = 30'h123;
    @(negedge clk); checkCtl("exc.accept", 4'b0000, 4'b1111, 1, 0);
    nextCycle(); setIdle(); ldHazard = 1; ifBusy = 1; irq = 1;
    @(negedge clk);
    checkCtl("exc.flush", 4'b0000, 4'b1111, 0, 0);
    checkOutput("exc.epc", {2'd0, epc}, 32'h123);
    checkOutput("exc.code", {29'd0, expCode}, 32'd3);
    checkOutput("exc.ie", {31'd0, ie}, 32'd0);
    nextCycle();
    @(negedge clk);
    checkCtl("exc.redirect", 4'b0000, 4'b0000, 0, 1);
    checkOutput("exc.new_pc", {2'd0, newPc}, 32'h40);
    nextCycle(); setIdle();
    @(negedge clk);
    checkCtl("exc.after", 4'b0000, 4'b0000, 0, 0);
    checkOutput("exc.new_pc_hold", {2'd0, newPc}, 32'h40);
    nextCycle();

    // Exception deferred by mem_busy, then mem_busy during FLUSH/REDIRECT.
    setIdle(); memEn = 1; memCode = 3'd3; memPc = 30'h155; memBusy = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); checkCtl($sformatf("defer.c%0d", c), 4'b1111, 4'b0000, 0, 0);
      nextCycle();
    end
    memBusy = 0;
    @(negedge clk); checkCtl("defer.accept", 4'b0000, 4'b1111, 1, 0);
    nextCycle(); setIdle(); memBusy = 1;
    @(negedge clk);
    checkCtl("defer.flush", 4'b0000, 4'b1111, 0, 0);
    checkOutput("defer.epc", {2'd0, epc}, 32'h155);
    nextCycle();
    @(negedge clk);
    checkCtl("defer.redirect", 4'b0000, 4'b0000, 0, 1);
    nextCycle(); setIdle();

    // ERET back to a saved PC of 0x200, with a load hazard in the same cycle.
    runException("pre_eret", 30'h200, 3'd5);
    setIdle(); memEn = 1; memOp = 2'd2; ldHazard = 1;
    @(negedge clk);
    checkCtl("eret", 4'b0000, 4'b1110, 0, 1);
    checkOutput("eret.new_pc", {2'd0, newPc}, 32'h200);
    nextCycle(); setIdle();
    @(negedge clk);
    checkOutput("eret.ie", {31'd0, ie}, 32'd1);
    checkOutput("eret.new_pc_hold", {2'd0, newPc}, 32'h200);
    checkCtl("eret.after", 4'b0000, 4'b0000, 0, 0);
    nextCycle();

    // Exception and interrupt together: exception cause wins.
    setIdle(); memEn = 1; irq = 1; memCode = 3'd2; memPc = 30'h77;
    @(negedge clk); checkCtl("excirq.accept", 4'b0000, 4'b1111, 1, 0);
    nextCycle(); setIdle();
    @(negedge clk);
    checkOutput("excirq.code", {29'd0, expCode}, 32'd2);
    checkOutput("excirq.ie", {31'd0, ie}, 32'd0);
    nextCycle(); nextCycle();

    // Re-enable, then an interrupt that coincides with an ERET.
    setIdle(); memEn = 1; memOp = 2'd2;
    @(negedge clk); checkOutput("eret2.new_pc", {2'd0, newPc}, 32'h77);
    nextCycle(); setIdle(); memEn = 1; irq = 1; memOp = 2'd2; memPc = 30'h99;
    @(negedge clk); checkCtl("irq.accept", 4'b0000, 4'b1111, 1, 0);
    nextCycle(); setIdle();
    @(negedge clk);
    checkOutput("irq.code", {29'd0, expCode}, 32'd1);
    checkOutput("irq.epc", {2'd0, epc}, 32'h99);
    checkOutput("irq.ie", {31'd0, ie}, 32'd0);
    nextCycle();
    @(negedge clk); checkCtl("irq.redirect", 4'b0000, 4'b0000, 0, 1);
    nextCycle();

    // Reset during FLUSH aborts the redirect.
    setIdle(); memEn = 1; memCode = 3'd4; memPc = 30'h321;
    @(negedge clk); checkCtl("abort.accept", 4'b0000, 4'b1111, 1, 0);
    nextCycle(); setIdle(); rst = 1;
    @(negedge clk); checkOutput("abort.rst_vld", {31'd0, newPcVld}, 32'd0);
    nextCycle(); rst = 0;
    @(negedge clk);
    checkCtl("abort.after", 4'b0000, 4'b0000, 0, 0);
    checkOutput("abort.new_pc", {2'd0, newPc}, 32'd0);
    checkOutput("abort.epc", {2'd0, epc}, 32'd0);
    checkOutput("abort.code", {29'd0, expCode}, 32'd0);
    checkOutput("abort.ie", {31'd0, ie}, 32'd0);
    nextCycle();
    @(negedge clk); checkCtl("abort.later", 4'b0000, 4'b0000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
